// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the MEM stage.
// State encodings for data-SRAM response tracking.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_discard.sv
// Counter of killed in-flight data-SRAM requests whose
// late data_ok beats must be dropped.
module resp_discard_cnt
  import mem_stage_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] inc_i,
  input  logic       dec_i,
  output logic       cnt_zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Increment and decrement on the same edge apply as a net change.
  assign cnt_d = cnt_q - CNT_W'(dec_i) + CNT_W'(inc_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: tracks data-SRAM responses, buffers
// load data while WB stalls, and drops responses of flushed ops.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_to_mem_valid,
  input  logic              exe_need_resp,
  output logic              mem_allow_in,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              wb_allow_in,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_ready_go,
  output logic              mem_to_wb_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              discard_pending
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              valid_q, valid_d;

  logic       cnt_zero;
  logic       resp_ok;
  logic       enter;
  logic       kill_wait;
  logic       kill_enter;
  logic [1:0] disc_inc;
  logic       disc_dec;
  mem_state_e entry_st;

  // A beat only belongs to the MEM op once older discards drained.
  assign resp_ok = data_sram_data_ok & cnt_zero;

  assign mem_valid    = valid_q;
  assign mem_ready_go = (state_q != MEM_WAIT) | resp_ok;
  assign mem_allow_in = ~valid_q | (mem_ready_go & wb_allow_in);
  assign mem_to_wb_valid = valid_q & mem_ready_go & ~flush;
  assign mem_rdata = (state_q == MEM_DONE) ? rbuf_q
                                           : data_sram_rdata;
  assign discard_pending = ~cnt_zero;

  assign enter = mem_allow_in & exe_to_mem_valid & ~flush;
  assign entry_st = (enter & exe_need_resp) ? MEM_WAIT
                                            : MEM_IDLE;

  assign kill_wait  = flush & (state_q == MEM_WAIT) & ~resp_ok;
  assign kill_enter = flush & exe_to_mem_valid & exe_need_resp;
  assign disc_inc   = {1'b0, kill_wait} + {1'b0, kill_enter};
  assign disc_dec   = data_sram_data_ok & ~cnt_zero;

  always_comb begin
    valid_d = valid_q;
    if (flush)             valid_d = 1'b0;
    else if (mem_allow_in) valid_d = exe_to_mem_valid;
  end

  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    if (flush) begin
      state_d = MEM_IDLE;
    end else begin
      unique case (state_q)
        MEM_IDLE: begin
          if (enter) state_d = entry_st;
        end
        MEM_WAIT: begin
          if (resp_ok) begin
            if (wb_allow_in) begin
              state_d = entry_st;
            end else begin
              state_d = MEM_DONE;
              rbuf_d  = data_sram_rdata;
            end
          end
        end
        MEM_DONE: begin
          if (wb_allow_in) state_d = entry_st;
        end
        default: state_d = MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      rbuf_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      valid_q <= valid_d;
    end
  end

  resp_discard_cnt #(
    .CNT_W(CNT_W)
  ) u_discard (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (disc_inc),
    .dec_i     (disc_dec),
    .cnt_zero_o(cnt_zero)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a WB-side
// scoreboard of expected load data.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_to_mem_valid;
  logic        exe_need_resp;
  logic        mem_allow_in;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        wb_allow_in;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready_go;
  logic        mem_to_wb_valid;
  logic [31:0] mem_rdata;
  logic        discard_pending;

  logic [31:0] sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  int p0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .DATA_W(32),
    .CNT_W (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_need_resp    (exe_need_resp),
    .mem_allow_in     (mem_allow_in),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .wb_allow_in      (wb_allow_in),
    .flush            (flush),
    .mem_valid        (mem_valid),
    .mem_ready_go     (mem_ready_go),
    .mem_to_wb_valid  (mem_to_wb_valid),
    .mem_rdata        (mem_rdata),
    .discard_pending  (discard_pending)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // WB-side scoreboard: every accepted transfer pops one entry.
  always @(negedge clk) begin
    if (!rst && mem_to_wb_valid && wb_allow_in) begin
      n_tests++;
      n_pop++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $error("FAIL sb_unexpected: observed %h expected none",
               mem_rdata);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        assert (mem_rdata === e) else begin
          n_fail++;
          $error("FAIL sb_rdata: observed %h expected %h",
                 mem_rdata, e);
        end
      end
    end
  end

  // Discard counter must never need more than 2^CNT_W-1 slots.
  always @(negedge clk) begin
    if (!rst) begin
      int nxt;
      nxt = int'(dut.u_discard.cnt_q) + int'(dut.disc_inc)
          - int'(dut.disc_dec);
      assert (nxt <= 3) else begin
        n_fail++;
        $error("FAIL cnt_overflow: observed %0d expected <=3",
               nxt);
      end
    end
  end

  initial begin
    rst               = 1'b1;
    exe_to_mem_valid  = 1'b0;
    exe_need_resp     = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    wb_allow_in       = 1'b0;
    flush             = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_ready_go", 32'(mem_ready_go), 32'd1);
    chk("rst_allow_in", 32'(mem_allow_in), 32'd1);
    chk("rst_to_wb", 32'(mem_to_wb_valid), 32'd0);
    chk("rst_pending", 32'(discard_pending), 32'd0);

    // Load enters, data_ok two cycles later, WB open.
    exe_to_mem_valid = 1'b1;
    exe_need_resp    = 1'b1;
    wb_allow_in      = 1'b1;
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    chk("ld_wait_rg", 32'(mem_ready_go), 32'd0);
    chk("ld_wait_towb", 32'(mem_to_wb_valid), 32'd0);
    chk("ld_wait_allow", 32'(mem_allow_in), 32'd0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_2222;
    sb_q.push_back(32'h1111_2222);
    #1;
    chk("ld_ok_towb", 32'(mem_to_wb_valid), 32'd1);
    chk("ld_ok_rdata", mem_rdata, 32'h1111_2222);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    #1;
    chk("ld_after_valid", 32'(mem_valid), 32'd0);

    // Response arrives while WB stalls: buffered in DONE.
    exe_to_mem_valid = 1'b1;
    exe_need_resp    = 1'b1;
    wb_allow_in      = 1'b0;
    tick();
    exe_to_mem_valid  = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("st_ok_towb", 32'(mem_to_wb_valid), 32'd1);
    chk("st_ok_allow", 32'(mem_allow_in), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0BAD_0BAD;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("done_rdata", mem_rdata, 32'hDEAD_BEEF);
      chk("done_allow", 32'(mem_allow_in), 32'd0);
      chk("done_towb", 32'(mem_to_wb_valid), 32'd1);
      tick();
    end
    wb_allow_in = 1'b1;
    sb_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("done_release", 32'(mem_allow_in), 32'd1);
    tick();
    data_sram_rdata = '0;

    // Flush in WAIT with an entering load: two beats to drop.
    exe_to_mem_valid = 1'b1;
    exe_need_resp    = 1'b1;
    tick();
    flush = 1'b1;
    #1;
    chk("fl_towb", 32'(mem_to_wb_valid), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_pending", 32'(discard_pending), 32'd1);
    chk("fl_valid", 32'(mem_valid), 32'd0);
    tick();
    exe_to_mem_valid  = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_0001;
    #1;
    chk("drop1_rg", 32'(mem_ready_go), 32'd0);
    chk("drop1_towb", 32'(mem_to_wb_valid), 32'd0);
    tick();
    data_sram_rdata = 32'hAAAA_0002;
    #1;
    chk("drop2_rg", 32'(mem_ready_go), 32'd0);
    chk("drop2_pending", 32'(discard_pending), 32'd1);
    tick();
    data_sram_rdata = 32'h600D_F00D;
    sb_q.push_back(32'h600D_F00D);
    #1;
    chk("drain_pending", 32'(discard_pending), 32'd0);
    chk("new_ld_towb", 32'(mem_to_wb_valid), 32'd1);
    chk("new_ld_rdata", mem_rdata, 32'h600D_F00D);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;

    // Flush coincides with the owed data_ok.
    exe_to_mem_valid = 1'b1;
    exe_need_resp    = 1'b1;
    tick();
    exe_to_mem_valid  = 1'b0;
    flush             = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    #1;
    chk("flok_towb", 32'(mem_to_wb_valid), 32'd0);
    tick();
    flush             = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    #1;
    chk("flok_pending", 32'(discard_pending), 32'd0);
    chk("flok_valid", 32'(mem_valid), 32'd0);
    chk("flok_rg", 32'(mem_ready_go), 32'd1);

    // Back-to-back non-memory ops, one per cycle.
    exe_to_mem_valid = 1'b1;
    exe_need_resp    = 1'b0;
    p0 = n_pop;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exe_to_mem_valid = 1'b0;
      sb_q.push_back(32'h0);
      #1;
      chk("b2b_towb", 32'(mem_to_wb_valid), 32'd1);
      chk("b2b_allow", 32'(mem_allow_in), 32'd1);
      chk("b2b_rg", 32'(mem_ready_go), 32'd1);
      tick();
    end
    #1;
    chk("b2b_count", 32'(n_pop - p0), 32'd4);
    chk("b2b_empty", 32'(mem_valid), 32'd0);

    // Reset asserted mid-WAIT with a discard outstanding.
    exe_to_mem_valid = 1'b1;
    exe_need_resp    = 1'b1;
    tick();
    exe_to_mem_valid = 1'b0;
    flush            = 1'b1;
    tick();
    flush            = 1'b0;
    exe_to_mem_valid = 1'b1;
    tick();
    exe_to_mem_valid = 1'b0;
    #1;
    chk("pre_rst_pending", 32'(discard_pending), 32'd1);
    chk("pre_rst_rg", 32'(mem_ready_go), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(mem_valid), 32'd0);
    chk("arst_rg", 32'(mem_ready_go), 32'd1);
    chk("arst_pending", 32'(discard_pending), 32'd0);
    chk("arst_allow", 32'(mem_allow_in), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
